// File: rtl/vga_pkg.sv
// Shared VGA widths, background state encoding and palette for the scrolling background.
package vga_pkg;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 11;
    localparam int unsigned RGB_W    = 12;

    typedef enum logic [1:0] {
        DAY   = 2'd0,
        DUSK  = 2'd1,
        NIGHT = 2'd2,
        DAWN  = 2'd3
    } bg_state_t;

    localparam logic [RGB_W-1:0] RGB_BLANK    = 12'h000;
    localparam logic [RGB_W-1:0] SKY_DAY      = 12'h55F;
    localparam logic [RGB_W-1:0] SKY_DUSK     = 12'hF84;
    localparam logic [RGB_W-1:0] SKY_NIGHT    = 12'h114;
    localparam logic [RGB_W-1:0] SKY_DAWN     = 12'hF84;
    localparam logic [RGB_W-1:0] GRASS_DARK   = 12'h0B0;
    localparam logic [RGB_W-1:0] GRASS_LIGHT  = 12'h0F0;
    localparam logic [RGB_W-1:0] GRASS_NIGHT  = 12'h060;
    localparam logic [RGB_W-1:0] GROUND_DAY   = 12'hA52;
    localparam logic [RGB_W-1:0] GROUND_NIGHT = 12'h521;

    function automatic logic [RGB_W-1:0] sky_colour(input bg_state_t s);
        logic [RGB_W-1:0] c;
        c = SKY_DAY;
        unique case (s)
            DAY:     c = SKY_DAY;
            DUSK:    c = SKY_DUSK;
            NIGHT:   c = SKY_NIGHT;
            DAWN:    c = SKY_DAWN;
            default: c = SKY_DAY;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus colour bundle passed between drawing stages.
interface vga_if;
    import vga_pkg::*;

    logic [VCOUNT_W-1:0] vcount;
    logic [HCOUNT_W-1:0] hcount;
    logic                vsync;
    logic                hsync;
    logic                vblnk;
    logic                hblnk;
    logic [RGB_W-1:0]    rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/bg_daynight_fsm.sv
// Day/night phase sequencer: dwells a fixed number of frames in each phase.
module bg_daynight_fsm
    import vga_pkg::*;
#(
    parameter int unsigned DAY_FRAMES   = 600,
    parameter int unsigned TRANS_FRAMES = 120
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      frame_tick,
    input  logic      cycle_en,
    output bg_state_t state
);

    localparam int unsigned MAX_FRAMES = (DAY_FRAMES > TRANS_FRAMES) ? DAY_FRAMES : TRANS_FRAMES;
    localparam int unsigned CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    bg_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] dwell_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DAY;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter only moves on enabled frame ticks, so a paused cycle resumes where it left off.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dwell_last = ((state == DAY) || (state == NIGHT)) ? CNT_W'(DAY_FRAMES - 1)
                                                           : CNT_W'(TRANS_FRAMES - 1);
        if (frame_tick && cycle_en) begin
            if (cnt == dwell_last) begin
                cnt_next = '0;
                unique case (state)
                    DAY:     state_next = DUSK;
                    DUSK:    state_next = NIGHT;
                    NIGHT:   state_next = DAWN;
                    DAWN:    state_next = DAY;
                    default: state_next = DAY;
                endcase
            end else begin
                cnt_next = cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/draw_bg_scroll.sv
// Background layer: sky tinted by day/night phase, scrolling striped grass, ground band.
module draw_bg_scroll
    import vga_pkg::*;
#(
    parameter int unsigned GRASS_TOP    = 675,
    parameter int unsigned GROUND_TOP   = 700,
    parameter int unsigned STRIPE_W     = 16,
    parameter int unsigned DAY_FRAMES   = 600,
    parameter int unsigned TRANS_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scroll_en,
    input  logic [3:0] speed,
    input  logic       cycle_en,
    vga_if.in          vin,
    vga_if.out         vout,
    output logic [1:0] phase
);

    localparam int unsigned OFF_W = $clog2(2 * STRIPE_W);
    localparam logic [VCOUNT_W-1:0] GRASS_TOP_V  = VCOUNT_W'(GRASS_TOP);
    localparam logic [VCOUNT_W-1:0] GROUND_TOP_V = VCOUNT_W'(GROUND_TOP);

    bg_state_t        state;
    logic             vblnk_prev;
    logic             frame_tick_c;
    logic [OFF_W-1:0] offset;
    logic [OFF_W-1:0] stripe_pos_c;
    logic [RGB_W-1:0] rgb_c;

    assign frame_tick_c = vin.vblnk & ~vblnk_prev;
    // Stripe period is a power of two, so the wrap is just the low bits of the sum.
    assign stripe_pos_c = vin.hcount[OFF_W-1:0] + offset;
    assign phase        = state;

    bg_daynight_fsm #(
        .DAY_FRAMES   (DAY_FRAMES),
        .TRANS_FRAMES (TRANS_FRAMES)
    ) u_daynight (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick_c),
        .cycle_en   (cycle_en),
        .state      (state)
    );

    always_comb begin
        rgb_c = RGB_BLANK;
        if (vin.vblnk || vin.hblnk) begin
            rgb_c = RGB_BLANK;
        end else if (vin.vcount <= GRASS_TOP_V) begin
            rgb_c = sky_colour(state);
        end else if (vin.vcount <= GROUND_TOP_V) begin
            if (state == NIGHT)
                rgb_c = GRASS_NIGHT;
            else
                rgb_c = stripe_pos_c[OFF_W-1] ? GRASS_LIGHT : GRASS_DARK;
        end else begin
            rgb_c = (state == NIGHT) ? GROUND_NIGHT : GROUND_DAY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vout.vcount <= '0;
            vout.hcount <= '0;
            vout.vsync  <= 1'b0;
            vout.hsync  <= 1'b0;
            vout.vblnk  <= 1'b0;
            vout.hblnk  <= 1'b0;
            vout.rgb    <= '0;
            vblnk_prev  <= 1'b0;
            offset      <= '0;
        end else begin
            vout.vcount <= vin.vcount;
            vout.hcount <= vin.hcount;
            vout.vsync  <= vin.vsync;
            vout.hsync  <= vin.hsync;
            vout.vblnk  <= vin.vblnk;
            vout.hblnk  <= vin.hblnk;
            vout.rgb    <= rgb_c;
            vblnk_prev  <= vin.vblnk;
            if (frame_tick_c && scroll_en)
                offset <= offset + OFF_W'(speed);
        end
    end

endmodule

// File: tb/tb_draw_bg_scroll.sv
// Randomized bench for draw_bg_scroll against a frame-level behavioural model.
module tb_draw_bg_scroll;

    localparam int GRASS_TOP  = 675;
    localparam int GROUND_TOP = 700;
    localparam int STRIPE_W   = 16;
    localparam int DAYF       = 4;
    localparam int TRF        = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scroll_en = 1'b0;
    logic [3:0] speed = 4'd0;
    logic       cycle_en = 1'b0;
    logic [1:0] phase;

    vga_if vin_if ();
    vga_if vout_if ();

    draw_bg_scroll #(
        .GRASS_TOP    (GRASS_TOP),
        .GROUND_TOP   (GROUND_TOP),
        .STRIPE_W     (STRIPE_W),
        .DAY_FRAMES   (DAYF),
        .TRANS_FRAMES (TRF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scroll_en (scroll_en),
        .speed     (speed),
        .cycle_en  (cycle_en),
        .vin       (vin_if.in),
        .vout      (vout_if.out),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: scroll offset as a plain integer, and total enabled frame ticks.
    int   m_off   = 0;
    int   m_ticks = 0;
    logic m_prev  = 1'b0;

    int ph_tab [12] = '{0, 0, 0, 1, 1, 2, 2, 2, 2, 3, 3, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_phase(input int t);
        int p;
        p = t % (2 * (DAYF + TRF));
        if (p < DAYF) return 0;
        if (p < DAYF + TRF) return 1;
        if (p < 2 * DAYF + TRF) return 2;
        return 3;
    endfunction

    function automatic logic [11:0] model_rgb(input int vc, input int hc, input logic vb,
                                              input logic hb, input int off, input int ph);
        if (vb || hb) return 12'h000;
        if (vc <= GRASS_TOP) begin
            case (ph)
                0: return 12'h55F;
                2: return 12'h114;
                default: return 12'hF84;
            endcase
        end
        if (vc <= GROUND_TOP) begin
            if (ph == 2) return 12'h060;
            return (((hc + off) % (2 * STRIPE_W)) < STRIPE_W) ? 12'h0B0 : 12'h0F0;
        end
        return (ph == 2) ? 12'h521 : 12'hA52;
    endfunction

    // One pixel cycle: drive vin, predict, clock, compare vout and phase.
    task automatic cyc(input logic r, input logic [10:0] vc, input logic [10:0] hc,
                       input logic vb, input logic hb);
        logic [11:0] exp_rgb;
        logic [31:0] exp_tim;
        logic        tick;
        logic        vs;
        logic        hs;
        vs = 1'($urandom);
        hs = 1'($urandom);
        rst           = r;
        vin_if.vcount = vc;
        vin_if.hcount = hc;
        vin_if.vsync  = vs;
        vin_if.hsync  = hs;
        vin_if.vblnk  = vb;
        vin_if.hblnk  = hb;
        vin_if.rgb    = 12'($urandom);
        exp_rgb = model_rgb(int'(vc), int'(hc), vb, hb, m_off, model_phase(m_ticks));
        exp_tim = {6'd0, vc, hc, vs, hs, vb, hb};
        tick    = vb & ~m_prev;
        @(posedge clk);
        #1;
        if (r) begin
            m_off   = 0;
            m_ticks = 0;
            m_prev  = 1'b0;
            check("rst_vout", {6'd0, vout_if.vcount, vout_if.hcount, vout_if.vsync,
                               vout_if.hsync, vout_if.vblnk, vout_if.hblnk}, 32'd0);
            check("rst_rgb", 32'(vout_if.rgb), 32'd0);
        end else begin
            if (tick && scroll_en) m_off = (m_off + int'(speed)) % (2 * STRIPE_W);
            if (tick && cycle_en) m_ticks++;
            m_prev = vb;
            check("timing", {6'd0, vout_if.vcount, vout_if.hcount, vout_if.vsync,
                             vout_if.hsync, vout_if.vblnk, vout_if.hblnk}, exp_tim);
            check("rgb", 32'(vout_if.rgb), 32'(exp_rgb));
        end
        check("phase", 32'(phase), 32'(model_phase(m_ticks)));
    endtask

    function automatic logic [10:0] pick_v();
        case ($urandom % 6)
            0: return 11'd675;
            1: return 11'd676;
            2: return 11'd700;
            3: return 11'd701;
            default: return 11'($urandom_range(0, 800));
        endcase
    endfunction

    task automatic rand_cyc(input logic vb);
        cyc(1'b0, pick_v(), 11'($urandom), vb, ($urandom % 8) == 0);
    endtask

    // A short frame: visible pixels followed by two blanking cycles (one frame tick).
    task automatic frame(input int nvis);
        repeat (nvis) rand_cyc(1'b0);
        repeat (2) rand_cyc(1'b1);
    endtask

    task automatic px(input string tag, input int vc, input int hc, input logic [11:0] exp);
        cyc(1'b0, 11'(vc), 11'(hc), 1'b0, 1'b0);
        check(tag, 32'(vout_if.rgb), 32'(exp));
    endtask

    initial begin
        vin_if.vcount = '0;
        vin_if.hcount = '0;
        vin_if.vsync  = 1'b0;
        vin_if.hsync  = 1'b0;
        vin_if.vblnk  = 1'b0;
        vin_if.hblnk  = 1'b0;
        vin_if.rgb    = '0;

        repeat (2) cyc(1'b1, 11'd680, 11'd5, 1'b0, 1'b0);
        check("rst_phase0", 32'(phase), 32'd0);

        // Pipeline and blanking with random timing, no scroll or cycling.
        repeat (200) rand_cyc(($urandom % 4) == 0);
        cyc(1'b0, 11'd680, 11'd3, 1'b1, 1'b0);
        check("blank_v", 32'(vout_if.rgb), 32'h000);
        cyc(1'b0, 11'd680, 11'd3, 1'b0, 1'b1);
        check("blank_h", 32'(vout_if.rgb), 32'h000);
        cyc(1'b0, 11'd600, 11'd3, 1'b0, 1'b0);

        // Band edges in DAY with offset 0.
        px("band_675", 675, 0, 12'h55F);
        px("band_676", 676, 0, 12'h0B0);
        px("band_700", 700, 16, 12'h0F0);
        px("band_701", 701, 0, 12'hA52);

        // Scroll wrap: 7 frames of speed 5 -> offset 35 mod 32 = 3.
        scroll_en = 1'b1;
        speed     = 4'd5;
        repeat (7) frame(3);
        scroll_en = 1'b0;
        px("wrap_h0", 680, 0, 12'h0B0);
        px("wrap_h12", 680, 12, 12'h0B0);
        px("wrap_h13", 680, 13, 12'h0F0);

        // Freeze: scroll disabled, pattern must not move.
        speed = 4'd7;
        repeat (3) frame(3);
        px("frz_h0", 680, 0, 12'h0B0);
        px("frz_h12", 680, 12, 12'h0B0);
        px("frz_h13", 680, 13, 12'h0F0);

        // Full day/night cycle, with a pause that must not lose the count.
        cycle_en = 1'b1;
        for (int k = 0; k < 12; k++) begin
            frame(2);
            check("fsm_phase", 32'(phase), 32'(ph_tab[k]));
            if (k == 1) begin
                cycle_en = 1'b0;
                repeat (3) frame(2);
                check("hold_phase", 32'(phase), 32'd0);
                cycle_en = 1'b1;
            end
            if (k == 3) px("dusk_sky", 600, 0, 12'hF84);
            if (k == 5) begin
                px("night_grass", 680, 0, 12'h060);
                px("night_ground", 701, 0, 12'h521);
                px("night_sky", 600, 0, 12'h114);
            end
            if (k == 9) px("dawn_sky", 600, 0, 12'hF84);
        end
        px("day_again", 600, 0, 12'h55F);

        // Reset during NIGHT with offset 9, coinciding with a vblnk rising edge.
        repeat (2) cyc(1'b1, 11'd0, 11'd0, 1'b0, 1'b0);
        scroll_en = 1'b1;
        speed     = 4'd9;
        frame(2);
        scroll_en = 1'b0;
        repeat (5) frame(2);
        check("pre_rst_phase", 32'(phase), 32'd2);
        px("pre_rst_grass", 680, 7, 12'h060);
        cyc(1'b1, 11'd680, 11'd5, 1'b1, 1'b0);
        check("mid_rst_phase", 32'(phase), 32'd0);
        cycle_en = 1'b0;
        px("post_rst_h0", 680, 0, 12'h0B0);
        px("post_rst_h16", 680, 16, 12'h0F0);
        px("post_rst_h7", 680, 7, 12'h0B0);

        // Random mix of scroll/cycle enables and speeds.
        for (int f = 0; f < 40; f++) begin
            scroll_en = 1'($urandom);
            cycle_en  = 1'($urandom);
            speed     = 4'($urandom);
            if (f == 20) cyc(1'b1, 11'd0, 11'd0, 1'($urandom), 1'b0);
            frame(int'($urandom_range(1, 6)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/draw_bg_scroll.md
DRAW_BG_SCROLL -- requirements
Module: draw_bg_scroll

Interface
REQ-001 SHALL have parameter GRASS_TOP, default 675: grass band occupies vcount > GRASS_TOP and vcount <= GROUND_TOP.
REQ-002 SHALL have parameter GROUND_TOP, default 700: ground band occupies vcount > GROUND_TOP.
REQ-003 SHALL have parameter STRIPE_W, default 16: grass stripe width in pixels; must be a power of two, 2..64.
REQ-004 SHALL have parameter DAY_FRAMES, default 600: frames spent in DAY and in NIGHT.
REQ-005 SHALL have parameter TRANS_FRAMES, default 120: frames spent in DUSK and in DAWN.
REQ-006 SHALL have port clk, input, 1: sole clock, all state on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port scroll_en, input, 1: 1 = advance scroll offset once per frame.
REQ-009 SHALL have port speed, input, 4: pixels of scroll added per frame; must be < 2*STRIPE_W.
REQ-010 SHALL have port cycle_en, input, 1: 1 = day/night FSM advances.
REQ-011 SHALL have port vin, vga_if.in: timing and rgb in.
REQ-012 SHALL have port vout, vga_if.out: timing delayed by one cycle, new rgb.
REQ-013 SHALL have port phase, output, 2: current FSM state code.

Function
REQ-014 SHALL register all vout timing fields (vcount, hcount, vsync, hsync, vblnk, hblnk) from vin with exactly 1-cycle latency.
REQ-015 SHALL register vout.rgb from a combinational value of the same-cycle vin fields, giving 1-cycle latency.
REQ-016 SHALL output rgb 12'h000 whenever vin.vblnk or vin.hblnk is high.
REQ-017 SHALL generate frame_tick on the rising edge of vin.vblnk, detected against a registered copy of the previous vin.vblnk.
REQ-018 SHALL keep a scroll offset of width log2(2*STRIPE_W).
- On frame_tick with scroll_en=1: offset <= (offset + speed) mod 2*STRIPE_W.
- Otherwise: offset holds.
REQ-019 SHALL, in the grass band, output dark grass 12'h0B0 when ((hcount + offset) mod 2*STRIPE_W) < STRIPE_W, else light grass 12'h0F0; the mod SHALL use the low bits only.
REQ-020 SHALL output ground 12'hA52 in the ground band.
REQ-021 SHALL output sky colour by state in the sky region (vcount <= GRASS_TOP): DAY 12'h55F, DUSK 12'hF84, NIGHT 12'h114, DAWN 12'hF84.
REQ-022 SHALL darken grass and ground to 12'h060/12'h521 in NIGHT only.
REQ-023 SHALL implement the FSM DAY(0) -> DUSK(1) -> NIGHT(2) -> DAWN(3) -> DAY; phase SHALL equal the state code.
REQ-024 SHALL count frame_ticks in a frame counter only while cycle_en=1.
- Transition when the count reaches the state's dwell minus 1 on a frame_tick.
- Counter clears to 0 on every transition.
REQ-025 SHALL hold the frame counter and state when cycle_en=0, and resume from the held count when cycle_en returns to 1.
REQ-026 SHALL apply offset and state changes made at a frame_tick from the next pixel onward; the value never changes within a visible frame.
REQ-027 SHALL treat band boundaries strictly: vcount=675 is sky, 676 is grass, 700 is grass, 701 is ground.

Reset
REQ-028 SHALL, on rst, clear all vout fields to 0, clear offset, frame counter and vblnk history to 0, and set state DAY (phase=0).
REQ-029 SHALL give rst priority over a simultaneous frame_tick; no first-tick-after-reset is lost or doubled.

Structure
REQ-030 SHALL place the state enum (DAY, DUSK, NIGHT, DAWN) and the colour constants in vga_pkg.
REQ-031 SHALL put the day/night FSM and frame counter in one sub-module, bg_daynight_fsm (inputs clk, rst, frame_tick, cycle_en; output state).

Verification
REQ-032 SHALL cover a pipeline check: random vin -> vout timing equals vin delayed 1 cycle; blanking gives rgb 000.
REQ-033 SHALL cover a band check: vcount 675/676/700/701 in DAY -> rgb 55F / stripe colour / stripe colour / A52.
REQ-034 SHALL cover a scroll wrap: STRIPE_W=16, speed=5, scroll_en=1, 7 frames -> offset 5,10,...,30,3; hcount=0 on frame 7 shows dark grass (3 < 16).
REQ-035 SHALL cover a scroll freeze: scroll_en=0 for 3 frames -> offset and stripe pattern unchanged.
REQ-036 SHALL cover an FSM cycle: DAY_FRAMES=4, TRANS_FRAMES=2 -> phase 0 for 4 ticks, 1 for 2, 2 for 4, 3 for 2, then 0; NIGHT grass = 060.
REQ-037 SHALL cover reset mid-operation: rst during NIGHT with offset=9 -> next cycle phase=0, offset=0, vout all 0.
